round_robin_arbiter_lock: RTL and testbench

Clocked, parametrised round-robin arbiter for the Phoenix router's switch-control path. It selects one of `SIZE` requesting input ports, registers the choice and holds it for the whole packet until an explicit release. A per-port mask excludes ports whose target is busy, and back-to-back re-arbitration happens on release with no idle cycle. It replaces the edge-triggered arbiter in the next router generation and is driven by the switch-control FSM.

---
 rtl/round_robin_arbiter_lock_if.sv | 28 ++
 rtl/round_robin_arbiter_lock.sv | 89 ++++++++
 tb/tb_round_robin_arbiter_lock.sv | 135 +++++++++++++
 3 files changed

// File: rtl/round_robin_arbiter_lock_if.sv
// Request/grant bundle between the switch-control FSM (master) and the round-robin arbiter (slave).
`ifndef NPORT
`define NPORT 5
`endif

interface round_robin_arbiter_lock_if #(
    parameter int SIZE  = `NPORT,
    parameter int IDX_W = $clog2(SIZE)
);
    logic [SIZE-1:0]  requests;
    logic [SIZE-1:0]  mask;
    logic             enable;
    // 'release' is a reserved word in SystemVerilog, hence the longer name.
    logic             releaseGrant;
    logic [SIZE-1:0]  grant;
    logic [IDX_W-1:0] selectedOutput;
    logic             isOutputSelected;

    modport master (
        output requests, mask, enable, releaseGrant,
        input  grant, selectedOutput, isOutputSelected
    );

    modport slave (
        input  requests, mask, enable, releaseGrant,
        output grant, selectedOutput, isOutputSelected
    );
endinterface

// File: rtl/round_robin_arbiter_lock.sv
// Round-robin arbiter that locks the winning port until an explicit release,
// with masked ports and same-cycle handover on release.
`ifndef NPORT
`define NPORT 5
`endif

module round_robin_arbiter_lock #(
    parameter int SIZE = `NPORT
) (
    input  logic                          clock,
    input  logic                          reset,
    round_robin_arbiter_lock_if.slave     bus
);
    localparam int IDX_W = $clog2(SIZE);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [IDX_W-1:0] r_lastport;
    logic [IDX_W-1:0] w_nextLastport;
    logic [IDX_W-1:0] w_winner;
    logic             w_found;
    logic [SIZE-1:0]  w_elig;
    int               w_dist;
    int               w_bestDist;

    assign w_elig = bus.requests & ~bus.mask;

    // Distance 0 is the port right after lastport; lastport itself is SIZE-1, so it is checked last.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_dist     = 0;
        w_bestDist = SIZE;
        for (int p = 0; p < SIZE; p++) begin
            w_dist = (p + SIZE - 1 - int'(r_lastport)) % SIZE;
            if (w_elig[p] && (w_dist < w_bestDist)) begin
                w_bestDist = w_dist;
                w_winner   = IDX_W'(p);
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextLastport = r_lastport;
        case (r_state)
            IDLE: begin
                if (bus.enable && w_found) begin
                    w_nextState    = GRANTED;
                    w_nextLastport = w_winner;
                end
            end
            GRANTED: begin
                if (bus.releaseGrant) begin
                    if (bus.enable && w_found) begin
                        w_nextLastport = w_winner;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lastport <= IDX_W'(SIZE - 1);
        end else begin
            r_state    <= w_nextState;
            r_lastport <= w_nextLastport;
        end
    end

    // While granted, lastport always names the owner, so outputs decode from registers only.
    always_comb begin
        bus.grant            = '0;
        bus.selectedOutput   = '0;
        bus.isOutputSelected = 1'b0;
        if (r_state == GRANTED) begin
            bus.grant            = SIZE'(1) << r_lastport;
            bus.selectedOutput   = r_lastport;
            bus.isOutputSelected = 1'b1;
        end
    end
endmodule

// File: tb/tb_round_robin_arbiter_lock.sv
// Bench for round_robin_arbiter_lock: directed scenarios followed by random traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_round_robin_arbiter_lock;
    localparam int SIZE  = 5;
    localparam int IDX_W = $clog2(SIZE);

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    bit   mGranted = 1'b0;
    int   mLast    = SIZE - 1;

    always #5 clock = ~clock;

    round_robin_arbiter_lock_if #(.SIZE(SIZE)) bus ();

    round_robin_arbiter_lock #(.SIZE(SIZE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // First eligible port scanning from the one after 'from', wrapping, 'from' last; -1 if none.
    function automatic int findWinner(input logic [SIZE-1:0] elig, input int from);
        int p;
        for (int k = 1; k <= SIZE; k++) begin
            p = (from + k) % SIZE;
            if (elig[p]) return p;
        end
        return -1;
    endfunction

    // Drives one cycle of inputs, advances the model over the same edge, then compares.
    task automatic applyStimulus(input logic [SIZE-1:0] req, input logic [SIZE-1:0] msk,
                                 input logic en, input logic rel, input logic rstn);
        int w;
        @(negedge clock);
        bus.requests     = req;
        bus.mask         = msk;
        bus.enable       = en;
        bus.releaseGrant = rel;
        reset            = rstn;
        @(posedge clock);
        #1;
        if (!rstn) begin
            mGranted = 1'b0;
            mLast    = SIZE - 1;
        end else if (!mGranted || rel) begin
            w = findWinner(req & ~msk, mLast);
            if (en && (w >= 0)) begin
                mGranted = 1'b1;
                mLast    = w;
            end else begin
                mGranted = 1'b0;
            end
        end
        checkOutput("grant", 32'(bus.grant), mGranted ? (32'd1 << mLast) : 32'd0);
        checkOutput("selectedOutput", 32'(bus.selectedOutput), mGranted ? 32'(mLast) : 32'd0);
        checkOutput("isOutputSelected", 32'(bus.isOutputSelected), 32'(mGranted));
    endtask

    initial begin
        bus.requests     = '0;
        bus.mask         = '0;
        bus.enable       = 1'b0;
        bus.releaseGrant = 1'b0;
        reset            = 1'b0;

        // Priority after reset
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        checkOutput("resetGrant", 32'(bus.grant), 32'd0);
        applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1);
        checkOutput("priorityGrant", 32'(bus.grant), 32'b00001);
        checkOutput("prioritySel", 32'(bus.selectedOutput), 32'd0);

        // Rotation with a release every third cycle
        for (int k = 0; k < 5; k++) begin
            applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1);
            applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1);
            applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b1, 1'b1);
            checkOutput("rotationSel", 32'(bus.selectedOutput), 32'((k + 1) % SIZE));
            checkOutput("rotationBusy", 32'(bus.isOutputSelected), 32'd1);
        end

        // Hold port 2 while requests and mask change
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00100, 5'b00000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(5'b00001, (k % 2 == 0) ? 5'b11111 : 5'b00000, 1'b1, 1'b0, 1'b1);
            checkOutput("holdGrant", 32'(bus.grant), 32'b00100);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b1, 1'b1);
        checkOutput("releaseIdle", 32'(bus.grant), 32'd0);
        applyStimulus(5'b01000, 5'b00000, 1'b0, 1'b0, 1'b1);
        checkOutput("idleNoEnable", 32'(bus.isOutputSelected), 32'd0);
        applyStimulus(5'b01000, 5'b00000, 1'b1, 1'b0, 1'b1);
        checkOutput("lateGrant", 32'(bus.grant), 32'b01000);

        // Reset mid-grant dominates release/enable
        applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b1, 1'b0);
        checkOutput("midResetGrant", 32'(bus.grant), 32'd0);
        applyStimulus(5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1);
        checkOutput("afterResetSel", 32'(bus.selectedOutput), 32'd0);

        // Mask and wrap: park lastport on 1, then winner 4, then wrap to 0
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00010, 5'b00000, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b1, 1'b1);
        applyStimulus(5'b10110, 5'b00100, 1'b1, 1'b0, 1'b1);
        checkOutput("maskWinner", 32'(bus.selectedOutput), 32'd4);
        applyStimulus(5'b00011, 5'b00000, 1'b1, 1'b1, 1'b1);
        checkOutput("wrapWinner", 32'(bus.selectedOutput), 32'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(SIZE'($urandom), SIZE'($urandom & $urandom),
                          ($urandom_range(3) != 0), ($urandom_range(2) == 0),
                          ($urandom_range(39) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
